// File: rtl/fixed_addsub_sat.sv
// Multi-lane pipelined signed fixed-point add/sub with saturate-or-wrap overflow,
// valid/ready flow control and a saturating overflow-event counter.

module fixed_addsub_lane #(
    parameter int BITS     = 8,
    parameter int SATURATE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s1_en,
    input  logic            s2_en,
    input  logic            s1_valid,
    input  logic            op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] c,
    output logic            ovf
);
    localparam logic [BITS-1:0] MAX_V = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] MIN_V = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS:0]   sum_d, sum_q;
    logic [BITS-1:0] c_d, c_q;
    logic            ovf_d, ovf_q;
    logic            over;
    logic [BITS:0]   ea, eb;

    always_comb begin
        ea    = {a[BITS-1], a};
        eb    = {b[BITS-1], b};
        sum_d = sum_q;
        if (s1_en)
            sum_d = op ? (ea - eb) : (ea + eb);
    end

    // Sign bit and the bit below it disagree exactly when the result left range.
    assign over = sum_q[BITS] ^ sum_q[BITS-1];

    always_comb begin
        c_d   = c_q;
        ovf_d = ovf_q;
        if (s2_en && s1_valid) begin
            ovf_d = over;
            if (SATURATE != 0 && over)
                c_d = sum_q[BITS] ? MIN_V : MAX_V;
            else
                c_d = sum_q[BITS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign c   = c_q;
    assign ovf = ovf_q;
endmodule

module fixed_addsub_sat #(
    parameter int    BITS      = 8,
    parameter string PRECISION = "FIXED_4_4",
    parameter int    LANES     = 1,
    parameter int    SATURATE  = 1,
    parameter int    CNT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic [LANES*BITS-1:0] a,
    input  logic [LANES*BITS-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*BITS-1:0] c,
    output logic [LANES-1:0]      ovf,
    input  logic                  clr_count,
    output logic [CNT_BITS-1:0]   ovf_count
);
    // vld_pipe_q[1] = S1 occupied, vld_pipe_q[2] = S2 occupied (out_valid).
    logic [2:1]          vld_pipe_d, vld_pipe_q;
    logic [CNT_BITS-1:0] cnt_d, cnt_q;
    logic                s1_en, s2_en;

    assign s2_en    = !vld_pipe_q[2] || out_ready;
    assign s1_en    = !vld_pipe_q[1] || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (s1_en) vld_pipe_d[1] = in_valid;
        if (s2_en) vld_pipe_d[2] = vld_pipe_q[1];
    end

    // Clear wins over a coincident increment; count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count)
            cnt_d = '0;
        else if (vld_pipe_q[2] && out_ready && (|ovf) && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fixed_addsub_lane #(
            .BITS     (BITS),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_en    (s1_en),
            .s2_en    (s2_en),
            .s1_valid (vld_pipe_q[1]),
            .op       (op),
            .a        (a[i*BITS +: BITS]),
            .b        (b[i*BITS +: BITS]),
            .c        (c[i*BITS +: BITS]),
            .ovf      (ovf[i])
        );
    end

    assign out_valid = vld_pipe_q[2];
    assign ovf_count = cnt_q;
endmodule
